// File: rtl/dii_packet_receiver.sv
// DII slave endpoint: takes one packet at a time, splits off the DEST/SRC/FLAGS header,
// buffers the payload and holds the complete packet for the consumer until it is acked.
module dii_packet_receiver #(
    parameter int MAX_PAYLOAD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               in_data,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      pkt_valid,
    input  logic                      pkt_ack,
    output logic [15:0]               pkt_dest,
    output logic [15:0]               pkt_src,
    output logic [15:0]               pkt_flags,
    output logic [7:0]                pkt_len,
    output logic [16*MAX_PAYLOAD-1:0] pkt_payload,
    output logic                      pkt_overflow,
    output logic [15:0]               drop_count
);

    typedef enum logic [2:0] {HDR_DEST, HDR_SRC, HDR_FLAGS, PAYLOAD, HOLD} state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t                            state_q, state_d;
    logic                              in_ready_q, in_ready_d;
    logic                              pkt_valid_q, pkt_valid_d;
    logic [15:0]                       dest_q, dest_d;
    logic [15:0]                       src_q, src_d;
    logic [15:0]                       flags_q, flags_d;
    logic [7:0]                        len_q, len_d;
    logic [MAX_PAYLOAD-1:0][15:0]      payload_q, payload_d;
    logic                              ovf_q, ovf_d;
    logic [15:0]                       drop_q, drop_d;
    logic                              xfer;
    logic [15:0]                       drop_inc;

    assign xfer     = in_valid & in_ready_q;
    assign drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        src_d     = src_q;
        flags_d   = flags_q;
        len_d     = len_q;
        payload_d = payload_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        case (state_q)
            HDR_DEST: if (xfer) begin
                dest_d = in_data;
                if (in_last) drop_d  = drop_inc;
                else         state_d = HDR_SRC;
            end
            HDR_SRC: if (xfer) begin
                src_d = in_data;
                if (in_last) begin
                    drop_d  = drop_inc;
                    state_d = HDR_DEST;
                end else begin
                    state_d = HDR_FLAGS;
                end
            end
            // The previous packet's payload is only wiped once a real header is complete,
            // so runts leave the stored len/payload untouched.
            HDR_FLAGS: if (xfer) begin
                flags_d   = in_data;
                len_d     = 8'd0;
                ovf_d     = 1'b0;
                payload_d = '0;
                state_d   = in_last ? HOLD : PAYLOAD;
            end
            PAYLOAD: if (xfer) begin
                if (len_q < MAX_LEN) begin
                    for (int i = 0; i < MAX_PAYLOAD; i++)
                        if (8'(i) == len_q) payload_d[i] = in_data;
                    len_d = len_q + 8'd1;
                end else begin
                    ovf_d = 1'b1;
                end
                if (in_last) state_d = HOLD;
            end
            HOLD: if (pkt_ack) state_d = HDR_DEST;
            default: state_d = HDR_DEST;
        endcase
        // Handshake outputs are registered copies of the next state.
        in_ready_d  = (state_d != HOLD);
        pkt_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HDR_DEST;
            in_ready_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            dest_q      <= '0;
            src_q       <= '0;
            flags_q     <= '0;
            len_q       <= '0;
            payload_q   <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            pkt_valid_q <= pkt_valid_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            flags_q     <= flags_d;
            len_q       <= len_d;
            payload_q   <= payload_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign pkt_valid    = pkt_valid_q;
    assign pkt_dest     = dest_q;
    assign pkt_src      = src_q;
    assign pkt_flags    = flags_q;
    assign pkt_len      = len_q;
    assign pkt_payload  = payload_q;
    assign pkt_overflow = ovf_q;
    assign drop_count   = drop_q;

endmodule

// File: doc/dii_packet_receiver.md
Name: dii_packet_receiver

Overview:
- Slave-side endpoint for the 16-bit DII debug channel (data/last/valid/ready).
- Accepts one packet at a time and parses the 3-word header: DEST, SRC, FLAGS.
- Buffers up to MAX_PAYLOAD payload words and presents the complete packet to local module logic with a valid/ack handshake.
- Counterpart of every DII master (packetizers, routers); sits at the input of each debug module.

Parameters:
- MAX_PAYLOAD, 8, payload word capacity; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  16  DII flit data
- in_last  in  1  final flit of packet
- in_valid  in  1  flit valid
- in_ready  out  1  receiver accepts a flit this cycle (registered)
- pkt_valid  out  1  complete packet held on pkt_* outputs
- pkt_ack  in  1  consumer releases the held packet
- pkt_dest  out  16  header word 0
- pkt_src  out  16  header word 1
- pkt_flags  out  16  header word 2
- pkt_len  out  8  number of stored payload words (0..MAX_PAYLOAD)
- pkt_payload  out  16*MAX_PAYLOAD  payload; word i at bits [16i+15:16i]
- pkt_overflow  out  1  packet carried more than MAX_PAYLOAD payload words
- drop_count  out  16  saturating count of runt packets (fewer than 3 words)

Behaviour:
- Transfer occurs when in_valid & in_ready at a rising edge. in_data/in_last are sampled only on a transfer.
- Reset (async, any time, including mid-packet):
  - state HDR_DEST; in_ready=0, pkt_valid=0, pkt_overflow=0.
  - pkt_dest/src/flags=0, pkt_len=0, pkt_payload all 0, drop_count=0.
  - Any partial packet is discarded.
  - in_ready=1 from the first edge after rst deasserts.
- States and transitions:
  - HDR_DEST: transfer stores pkt_dest. If in_last: runt, drop_count++ (saturate at 0xFFFF), stay. Else -> HDR_SRC.
  - HDR_SRC: transfer stores pkt_src. If in_last: runt, drop_count++, -> HDR_DEST. Else -> HDR_FLAGS.
  - HDR_FLAGS: transfer stores pkt_flags and clears pkt_len, pkt_overflow and all pkt_payload words to 0.
    - If in_last -> HOLD (zero-length payload). Else -> PAYLOAD.
  - PAYLOAD, each transfer:
    - If pkt_len < MAX_PAYLOAD: write payload[pkt_len], then pkt_len++.
    - Else: discard the word, set pkt_overflow=1; pkt_len stays at MAX_PAYLOAD.
    - If in_last -> HOLD.
  - HOLD: pkt_valid=1, in_ready=0. pkt_ack sampled high -> HDR_DEST.
- Registered handshake timing:
  - The edge accepting the final flit sets pkt_valid=1 and in_ready=0 simultaneously.
  - The edge sampling pkt_ack in HOLD sets pkt_valid=0 and in_ready=1 simultaneously.
  - Latency: last flit -> pkt_valid is 1 cycle. Ack -> next flit acceptable is 1 cycle.
  - Minimum packet period is (flits + 1) cycles with ack tied high.
- in_ready=1 in every state except HOLD; no back-pressure mid-packet.
- pkt_ack outside HOLD is ignored.
- All pkt_* outputs remain stable while pkt_valid=1.
- Outside HOLD, pkt_* outputs hold the previous packet, then the header of the packet being received as it is written; they are meaningful only while pkt_valid=1.
- Payload words at index >= pkt_len read 0 while pkt_valid=1.
- Runt packets never assert pkt_valid and do not disturb the previously stored payload or len. pkt_dest/pkt_src may be overwritten by a runt.
- Headers are not filtered on DEST; every complete packet is presented.

Test Plan:
- Reset, then send flits 0x0005,0x0001,0x4000,0xAAAA,0xBBBB(last) with pkt_ack=0 -> one cycle after last: pkt_valid=1, in_ready=0, dest=0x0005, src=0x0001, flags=0x4000, len=2, payload[0]=0xAAAA, payload[1]=0xBBBB, payload[2..7]=0, overflow=0. Pulse pkt_ack -> next cycle pkt_valid=0, in_ready=1.
- 3-word packet 0x0002,0x0003,0x8000(last) -> pkt_valid=1, len=0, all payload 0.
- MAX_PAYLOAD=8, 12 payload words 0x0100..0x010B -> len=8, payload[7]=0x0107, overflow=1. The next normal packet clears overflow to 0.
- Runts: single flit 0x0001(last), then 2-flit packet (last on word 2) -> pkt_valid never asserts, drop_count=2. A following valid packet is received correctly.
- Back-to-back packets with in_valid held high and pkt_ack tied 1 -> every packet delivered, in_ready low exactly one cycle per packet, no flit lost or duplicated. A random in_valid gap pattern yields identical results.
- Assert rst mid-payload (after 2 payload words), release, send a full packet -> only the new packet is presented; drop_count=0. Force 65 536 runts -> drop_count saturates at 0xFFFF.
